// File: rtl/ir_cursor_control.sv
// Remote-control cursor: turns qualified direction lines into a clamped (X,Y) position
// with one step per press followed by hold-delay auto-repeat while the key stays held.
module ir_cursor_control #(
   parameter int unsigned H_MAX         = 639,
   parameter int unsigned V_MAX         = 479,
   parameter int unsigned STEP          = 8,
   parameter int unsigned HOLD_CYCLES   = 12_500_000,
   parameter int unsigned REPEAT_CYCLES = 2_500_000,
   parameter int unsigned X_INIT        = 320,
   parameter int unsigned Y_INIT        = 240
) (
   input  logic       Clock,
   input  logic       Reset,
   input  logic       Up,
   input  logic       Down,
   input  logic       Left,
   input  logic       Right,
   input  logic       Readable,
   output logic [9:0] Cursor_X,
   output logic [9:0] Cursor_Y,
   output logic       Moved
);

   localparam int unsigned PW      = 10;
   localparam int unsigned AW      = 11;
   localparam int unsigned CNT_MAX = (HOLD_CYCLES > REPEAT_CYCLES) ? HOLD_CYCLES : REPEAT_CYCLES;
   localparam int unsigned CW      = (CNT_MAX > 2) ? $clog2(CNT_MAX) : 1;

   localparam logic [CW-1:0] HOLD_LAST   = CW'(HOLD_CYCLES - 1);
   localparam logic [CW-1:0] REPEAT_LAST = CW'(REPEAT_CYCLES - 1);
   localparam logic [AW-1:0] STEP_W      = AW'(STEP);
   localparam logic [AW-1:0] H_LIM       = AW'(H_MAX);
   localparam logic [AW-1:0] V_LIM       = AW'(V_MAX);

   typedef enum logic [1:0] {
      ST_IDLE,
      ST_HOLD,
      ST_REPEAT
   } state_e;

   typedef enum logic [2:0] {
      DIR_NONE,
      DIR_UP,
      DIR_DOWN,
      DIR_LEFT,
      DIR_RIGHT
   } dir_e;

   state_e        state_q, state_d;
   dir_e          dir_q, dir_d;
   dir_e          smp_dir_q, smp_dir_d;
   logic          smp_vld_q, smp_vld_d;
   logic [CW-1:0] cnt_q, cnt_d;
   logic [PW-1:0] x_q, x_d;
   logic [PW-1:0] y_q, y_d;
   logic          moved_q, moved_d;

   logic          step_en;
   dir_e          step_dir;
   logic          expired;

   // Clamped decrement toward zero.
   function automatic logic [PW-1:0] pos_dec(input logic [PW-1:0] v);
      logic [AW-1:0] w;
      w = AW'(v);
      if (w < STEP_W) begin
         return '0;
      end
      return PW'(w - STEP_W);
   endfunction

   // Clamped increment toward the given upper bound.
   function automatic logic [PW-1:0] pos_inc(input logic [PW-1:0] v, input logic [AW-1:0] lim);
      logic [AW-1:0] w;
      w = AW'(v) + STEP_W;
      if (w > lim) begin
         return PW'(lim);
      end
      return PW'(w);
   endfunction

   // Input sample stage: priority-encode one direction; Readable=0 yields no sample.
   always_comb begin
      smp_vld_d = Readable;
      smp_dir_d = DIR_NONE;
      if (Readable) begin
         if (Up) begin
            smp_dir_d = DIR_UP;
         end else if (Down) begin
            smp_dir_d = DIR_DOWN;
         end else if (Left) begin
            smp_dir_d = DIR_LEFT;
         end else if (Right) begin
            smp_dir_d = DIR_RIGHT;
         end
      end
   end

   assign expired = (state_q == ST_HOLD)   ? (cnt_q == HOLD_LAST)   :
                    (state_q == ST_REPEAT) ? (cnt_q == REPEAT_LAST) : 1'b0;

   // Press/hold/repeat FSM; release beats a new direction, which beats expiry.
   always_comb begin
      state_d  = state_q;
      dir_d    = dir_q;
      cnt_d    = cnt_q;
      step_en  = 1'b0;
      step_dir = DIR_NONE;
      case (state_q)
         ST_IDLE: begin
            if (smp_vld_q && (smp_dir_q != DIR_NONE)) begin
               step_en  = 1'b1;
               step_dir = smp_dir_q;
               dir_d    = smp_dir_q;
               state_d  = ST_HOLD;
               cnt_d    = '0;
            end
         end
         ST_HOLD, ST_REPEAT: begin
            cnt_d = cnt_q + CW'(1);
            if (smp_vld_q && (smp_dir_q == DIR_NONE)) begin
               state_d = ST_IDLE;
               dir_d   = DIR_NONE;
               cnt_d   = '0;
            end else if (smp_vld_q && (smp_dir_q != dir_q)) begin
               step_en  = 1'b1;
               step_dir = smp_dir_q;
               dir_d    = smp_dir_q;
               state_d  = ST_HOLD;
               cnt_d    = '0;
            end else if (expired) begin
               step_en  = 1'b1;
               step_dir = dir_q;
               state_d  = ST_REPEAT;
               cnt_d    = '0;
            end
         end
         default: begin
            state_d = ST_IDLE;
            dir_d   = DIR_NONE;
            cnt_d   = '0;
         end
      endcase
   end

   // Position update; Moved only when a coordinate actually changes.
   always_comb begin
      x_d = x_q;
      y_d = y_q;
      if (step_en) begin
         case (step_dir)
            DIR_UP:    y_d = pos_dec(y_q);
            DIR_DOWN:  y_d = pos_inc(y_q, V_LIM);
            DIR_LEFT:  x_d = pos_dec(x_q);
            DIR_RIGHT: x_d = pos_inc(x_q, H_LIM);
            default: begin
               x_d = x_q;
               y_d = y_q;
            end
         endcase
      end
      moved_d = (x_d != x_q) || (y_d != y_q);
   end

   always_ff @(posedge Clock) begin
      if (Reset) begin
         state_q   <= ST_IDLE;
         dir_q     <= DIR_NONE;
         smp_dir_q <= DIR_NONE;
         smp_vld_q <= 1'b0;
         cnt_q     <= '0;
         x_q       <= PW'(X_INIT);
         y_q       <= PW'(Y_INIT);
         moved_q   <= 1'b0;
      end else begin
         state_q   <= state_d;
         dir_q     <= dir_d;
         smp_dir_q <= smp_dir_d;
         smp_vld_q <= smp_vld_d;
         cnt_q     <= cnt_d;
         x_q       <= x_d;
         y_q       <= y_d;
         moved_q   <= moved_d;
      end
   end

   assign Cursor_X = x_q;
   assign Cursor_Y = y_q;
   assign Moved    = moved_q;

endmodule

// File: tb/tb_ir_cursor_control.sv
// Scoreboard bench for ir_cursor_control: a main instance at (320,240) and an
// edge instance at (4,476) for clamp scenarios, both with HOLD=4, REPEAT=2.
module tb_ir_cursor_control;

   typedef struct packed {
      logic [9:0] x;
      logic [9:0] y;
      logic       m;
   } exp_t;

   localparam logic [4:0] S_OFF  = 5'b00000;
   localparam logic [4:0] S_NONE = 5'b10000;
   localparam logic [4:0] S_UP   = 5'b11000;
   localparam logic [4:0] S_DN   = 5'b10100;
   localparam logic [4:0] S_LF   = 5'b10010;
   localparam logic [4:0] S_RT   = 5'b10001;

   logic       Clock = 1'b0;
   logic       Reset = 1'b1;
   logic       Up = 1'b0, Down = 1'b0, Left = 1'b0, Right = 1'b0, Readable = 1'b0;
   logic [9:0] m_x, m_y, e_x, e_y;
   logic       m_moved, e_moved;

   int checks   = 0;
   int failures = 0;
   exp_t sb_q[$];

   always #5 Clock = ~Clock;

   ir_cursor_control #(
      .H_MAX(639), .V_MAX(479), .STEP(8), .HOLD_CYCLES(4), .REPEAT_CYCLES(2),
      .X_INIT(320), .Y_INIT(240)
   ) u_main (
      .Clock(Clock), .Reset(Reset), .Up(Up), .Down(Down), .Left(Left), .Right(Right),
      .Readable(Readable), .Cursor_X(m_x), .Cursor_Y(m_y), .Moved(m_moved)
   );

   ir_cursor_control #(
      .H_MAX(639), .V_MAX(479), .STEP(8), .HOLD_CYCLES(4), .REPEAT_CYCLES(2),
      .X_INIT(4), .Y_INIT(476)
   ) u_edge (
      .Clock(Clock), .Reset(Reset), .Up(Up), .Down(Down), .Left(Left), .Right(Right),
      .Readable(Readable), .Cursor_X(e_x), .Cursor_Y(e_y), .Moved(e_moved)
   );

   task automatic drive(input logic [4:0] s);
      Readable = s[4];
      Up       = s[3];
      Down     = s[2];
      Left     = s[1];
      Right    = s[0];
   endtask

   task automatic do_reset();
      Reset = 1'b1;
      drive(S_OFF);
      repeat (2) @(posedge Clock);
      #1;
      Reset = 1'b0;
   endtask

   task automatic test_reset();
      exp_t e, g;
      Reset = 1'b1;
      drive(S_OFF);
      for (int i = 0; i < 8; i++) begin
         if (i == 2) Reset = 1'b0;
         drive(i >= 5 ? 5'b01000 : S_OFF);
         e = '{x: 10'd320, y: 10'd240, m: 1'b0};
         sb_q.push_back(e);
         @(posedge Clock);
         #1;
         g = sb_q.pop_front();
         checks++;
         if ({m_x, m_y, m_moved} !== {g.x, g.y, g.m}) begin
            failures++;
            $display("FAIL reset i=%0d got x=%0d y=%0d moved=%0b want x=%0d y=%0d moved=%0b",
                     i, m_x, m_y, m_moved, g.x, g.y, g.m);
         end
      end
   endtask

   task automatic test_single_step();
      exp_t e, g;
      logic [4:0] stim [7];
      stim = '{S_RT, S_NONE, 5'b00001, 5'b00001, 5'b00001, S_OFF, S_OFF};
      do_reset();
      for (int i = 0; i < 7; i++) begin
         drive(stim[i]);
         e = '{x: (i >= 1) ? 10'd328 : 10'd320, y: 10'd240, m: (i == 1)};
         sb_q.push_back(e);
         @(posedge Clock);
         #1;
         g = sb_q.pop_front();
         checks++;
         if ({m_x, m_y, m_moved} !== {g.x, g.y, g.m}) begin
            failures++;
            $display("FAIL single_step i=%0d got x=%0d y=%0d moved=%0b want x=%0d y=%0d moved=%0b",
                     i, m_x, m_y, m_moved, g.x, g.y, g.m);
         end
      end
   endtask

   task automatic test_auto_repeat();
      exp_t e, g;
      do_reset();
      for (int i = 0; i < 11; i++) begin
         drive(i == 0 ? S_UP : S_OFF);
         e.x = 10'd320;
         e.y = (i < 1) ? 10'd240 : (i < 5) ? 10'd232 : (i < 7) ? 10'd224 : (i < 9) ? 10'd216 : 10'd208;
         e.m = (i == 1) || (i == 5) || (i == 7) || (i == 9);
         sb_q.push_back(e);
         @(posedge Clock);
         #1;
         g = sb_q.pop_front();
         checks++;
         if ({m_x, m_y, m_moved} !== {g.x, g.y, g.m}) begin
            failures++;
            $display("FAIL auto_repeat i=%0d got x=%0d y=%0d moved=%0b want x=%0d y=%0d moved=%0b",
                     i, m_x, m_y, m_moved, g.x, g.y, g.m);
         end
      end
   endtask

   task automatic test_same_dir();
      exp_t e, g;
      logic [4:0] stim [8];
      stim = '{S_UP, S_OFF, S_UP, S_OFF, S_UP, S_OFF, S_OFF, S_OFF};
      do_reset();
      for (int i = 0; i < 8; i++) begin
         drive(stim[i]);
         e.x = 10'd320;
         e.y = (i < 1) ? 10'd240 : (i < 5) ? 10'd232 : (i < 7) ? 10'd224 : 10'd216;
         e.m = (i == 1) || (i == 5) || (i == 7);
         sb_q.push_back(e);
         @(posedge Clock);
         #1;
         g = sb_q.pop_front();
         checks++;
         if ({m_x, m_y, m_moved} !== {g.x, g.y, g.m}) begin
            failures++;
            $display("FAIL same_dir i=%0d got x=%0d y=%0d moved=%0b want x=%0d y=%0d moved=%0b",
                     i, m_x, m_y, m_moved, g.x, g.y, g.m);
         end
      end
   endtask

   task automatic test_priority();
      exp_t e, g;
      logic [4:0] stim [6];
      logic [9:0] ys [6];
      stim = '{5'b11111, S_NONE, S_NONE, 5'b10110, S_NONE, S_NONE};
      ys   = '{10'd240, 10'd232, 10'd232, 10'd232, 10'd240, 10'd240};
      do_reset();
      for (int i = 0; i < 6; i++) begin
         drive(stim[i]);
         e = '{x: 10'd320, y: ys[i], m: (i == 1) || (i == 4)};
         sb_q.push_back(e);
         @(posedge Clock);
         #1;
         g = sb_q.pop_front();
         checks++;
         if ({m_x, m_y, m_moved} !== {g.x, g.y, g.m}) begin
            failures++;
            $display("FAIL priority i=%0d got x=%0d y=%0d moved=%0b want x=%0d y=%0d moved=%0b",
                     i, m_x, m_y, m_moved, g.x, g.y, g.m);
         end
      end
   endtask

   task automatic test_change_in_hold();
      exp_t e, g;
      do_reset();
      for (int i = 0; i < 10; i++) begin
         drive(i == 0 ? S_UP : (i == 2 ? S_LF : S_OFF));
         e.y = (i >= 1) ? 10'd232 : 10'd240;
         e.x = (i < 3) ? 10'd320 : (i < 7) ? 10'd312 : (i < 9) ? 10'd304 : 10'd296;
         e.m = (i == 1) || (i == 3) || (i == 7) || (i == 9);
         sb_q.push_back(e);
         @(posedge Clock);
         #1;
         g = sb_q.pop_front();
         checks++;
         if ({m_x, m_y, m_moved} !== {g.x, g.y, g.m}) begin
            failures++;
            $display("FAIL change_in_hold i=%0d got x=%0d y=%0d moved=%0b want x=%0d y=%0d moved=%0b",
                     i, m_x, m_y, m_moved, g.x, g.y, g.m);
         end
      end
   endtask

   task automatic test_back_to_back();
      exp_t e, g;
      logic [4:0] stim [7];
      logic [9:0] xs [7];
      logic [9:0] ys [7];
      stim = '{S_RT, S_DN, S_LF, S_UP, S_NONE, S_OFF, S_OFF};
      xs   = '{10'd320, 10'd328, 10'd328, 10'd320, 10'd320, 10'd320, 10'd320};
      ys   = '{10'd240, 10'd240, 10'd248, 10'd248, 10'd240, 10'd240, 10'd240};
      do_reset();
      for (int i = 0; i < 7; i++) begin
         drive(stim[i]);
         e = '{x: xs[i], y: ys[i], m: (i >= 1) && (i <= 4)};
         sb_q.push_back(e);
         @(posedge Clock);
         #1;
         g = sb_q.pop_front();
         checks++;
         if ({m_x, m_y, m_moved} !== {g.x, g.y, g.m}) begin
            failures++;
            $display("FAIL back_to_back i=%0d got x=%0d y=%0d moved=%0b want x=%0d y=%0d moved=%0b",
                     i, m_x, m_y, m_moved, g.x, g.y, g.m);
         end
      end
   endtask

   task automatic test_clamp_low();
      exp_t e, g;
      logic [4:0] stim [9];
      stim = '{S_LF, S_NONE, S_LF, S_NONE, S_DN, S_NONE, S_DN, S_NONE, S_OFF};
      do_reset();
      for (int i = 0; i < 9; i++) begin
         drive(stim[i]);
         e.x = (i == 0) ? 10'd4 : 10'd0;
         e.y = (i < 5) ? 10'd476 : 10'd479;
         e.m = (i == 1) || (i == 5);
         sb_q.push_back(e);
         @(posedge Clock);
         #1;
         g = sb_q.pop_front();
         checks++;
         if ({e_x, e_y, e_moved} !== {g.x, g.y, g.m}) begin
            failures++;
            $display("FAIL clamp_low i=%0d got x=%0d y=%0d moved=%0b want x=%0d y=%0d moved=%0b",
                     i, e_x, e_y, e_moved, g.x, g.y, g.m);
         end
      end
   endtask

   // Holding Right from X=4 walks through 636 and pins at 639.
   task automatic test_clamp_high();
      exp_t e, g;
      int k;
      int xv;
      logic [9:0] prev_x;
      prev_x = 10'd4;
      do_reset();
      for (int i = 0; i < 170; i++) begin
         drive(i == 0 ? S_RT : S_OFF);
         k  = (i < 1) ? 0 : (i < 5) ? 1 : 2 + (i - 5) / 2;
         xv = 4 + 8 * k;
         if (xv > 639) xv = 639;
         e.x = 10'(xv);
         e.y = 10'd476;
         e.m = (e.x != prev_x);
         prev_x = e.x;
         sb_q.push_back(e);
         @(posedge Clock);
         #1;
         g = sb_q.pop_front();
         checks++;
         if ({e_x, e_y, e_moved} !== {g.x, g.y, g.m}) begin
            failures++;
            $display("FAIL clamp_high i=%0d got x=%0d y=%0d moved=%0b want x=%0d y=%0d moved=%0b",
                     i, e_x, e_y, e_moved, g.x, g.y, g.m);
         end
      end
   endtask

   task automatic test_reset_mid_repeat();
      exp_t e, g;
      do_reset();
      for (int i = 0; i < 14; i++) begin
         drive(i == 0 ? S_UP : S_OFF);
         Reset = (i == 6);
         e.x = 10'd320;
         e.y = (i < 1) ? 10'd240 : (i < 5) ? 10'd232 : (i < 6) ? 10'd224 : 10'd240;
         e.m = (i == 1) || (i == 5);
         sb_q.push_back(e);
         @(posedge Clock);
         #1;
         g = sb_q.pop_front();
         checks++;
         if ({m_x, m_y, m_moved} !== {g.x, g.y, g.m}) begin
            failures++;
            $display("FAIL reset_mid_repeat i=%0d got x=%0d y=%0d moved=%0b want x=%0d y=%0d moved=%0b",
                     i, m_x, m_y, m_moved, g.x, g.y, g.m);
         end
      end
      Reset = 1'b0;
   endtask

   initial begin
      test_reset();
      test_single_step();
      test_auto_repeat();
      test_same_dir();
      test_priority();
      test_change_in_hold();
      test_back_to_back();
      test_clamp_low();
      test_clamp_high();
      test_reset_mid_repeat();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
